// File: rtl/axi_lite_cfg_master_pkg.sv
// axi_lite_cfg_master_pkg: shared FSM state encoding and AXI response codes
package axi_lite_cfg_master_pkg;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_e;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_timeout_counter.sv
// axi_lite_timeout_counter: cycle counter that flags expiry after CYCLES-1 enabled cycles
module axi_lite_timeout_counter #(
   parameter int unsigned CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int unsigned W = $clog2(CYCLES) + 1;
   logic [W-1:0] count_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) count_q <= '0;
      else if (clear_i) count_q <= '0;
      else if (enable_i && !expired_o) count_q <= count_q + 1'b1;
   assign expired_o = count_q == W'(CYCLES - 1);
endmodule

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master: single-outstanding AXI-Lite initiator behind a valid/ready command port.
// Optional bus-recovery timeout enabled by AXI_LITE_CFG_MASTER_TIMEOUT_EN.
module axi_lite_cfg_master
   import axi_lite_cfg_master_pkg::*;
#(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);
   localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
   logic [DW/8-1:0] wstrb_q, wstrb_d;
   logic [1:0]      resp_q, resp_d;
   logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic            arvalid_q, arvalid_d, rready_q, rready_d, timeout_q, timeout_d;
`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
   logic expired, busy;
   assign busy = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
   axi_lite_timeout_counter #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i     (M_AXI_ACLK),
      .rst_ni    (M_AXI_ARESETN),
      .clear_i   (cmd_valid && cmd_ready),
      .enable_i  (busy),
      .expired_o (expired)
   );
`endif
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            addr_d    = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            timeout_d = 1'b0;
            state_d   = cmd_write ? WR_REQ : RD_REQ;
            awvalid_d = cmd_write;
            wvalid_d  = cmd_write;
            arvalid_d = !cmd_write;
         end
         // AW and W retire independently; B is only accepted once both are gone
         WR_REQ: begin
            awvalid_d = awvalid_q && !M_AXI_AWREADY;
            wvalid_d  = wvalid_q && !M_AXI_WREADY;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: if (M_AXI_BVALID) begin
            bready_d = 1'b0;
            resp_d   = M_AXI_BRESP;
            rdata_d  = '0;
            state_d  = RSP;
         end
         RD_REQ: if (M_AXI_ARREADY) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RD_DATA;
         end
         RD_DATA: if (M_AXI_RVALID) begin
            rready_d = 1'b0;
            rdata_d  = M_AXI_RDATA;
            resp_d   = M_AXI_RRESP;
            state_d  = RSP;
         end
         RSP: state_d = rsp_ready ? IDLE : RSP;
         default: state_d = IDLE;
      endcase
`ifdef AXI_LITE_CFG_MASTER_TIMEOUT_EN
      // Abandon the slave outright so the bus can recover from a hung target
      if (expired && busy) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         rdata_d   = '0;
         resp_d    = RESP_SLVERR;
         timeout_d = 1'b1;
         state_d   = RSP;
      end
`endif
   end
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
      if (!M_AXI_ARESETN) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         timeout_q <= timeout_d;
      end
   assign cmd_ready     = state_q == IDLE;
   assign rsp_valid     = state_q == RSP;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
   assign rsp_timeout   = timeout_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
endmodule

// File: doc/axi_lite_cfg_master.md
# axi_lite_cfg_master

AXI-Lite initiator that turns a simple valid/ready command port into single AXI-Lite read or write transactions. It sits in the FPGA emulation shell between a local controller and the AXI-Lite configuration slaves, such as the address-offset register block. It performs one transaction at a time and returns the read data and response on a held response port.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, AXI-Lite address width
- C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width (32 or 64)
- TIMEOUT_CYCLES, 1024, abort threshold in cycles (used only with timeout feature)
- M_AXI_ACLK  in  1  single clock; all logic on rising edge
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  target address
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction aborted by the timeout
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in  ADDR/3/1/1  write-address channel
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in  DATA/DATA/8/1/1  write-data channel
- M_AXI_BRESP/BVALID in, BREADY out  2/1/1  write-response channel
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in  ADDR/3/1/1  read-address channel
- M_AXI_RDATA/RRESP/RVALID in, RREADY out  DATA/2/1/1  read-data channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- cmd_ready is 1 only in IDLE. Acceptance (cmd_valid & cmd_ready) registers addr/data/strb and goes to WR_REQ or RD_REQ.
- WR_REQ: AWVALID and WVALID rise together and are tracked independently. Each one drops on its own handshake; they may complete in the same cycle or in different cycles. The state leaves for WR_RESP once both have completed.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set rsp_rdata = 0, go to RSP.
- RD_REQ: ARVALID = 1 until ARREADY, then RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP: rsp_valid = 1. The payload is held stable until rsp_ready, then the state returns to IDLE.
- AWPROT = ARPROT = 3'b000. Addresses are passed through unmodified.
- Commands presented while busy are not accepted.
- A BVALID before both AW and W have completed is ignored (BREADY is low).

## Timing
- Reset values: all *VALID, BREADY, RREADY, and rsp_* outputs are 0; address/data outputs are 0; state is IDLE, so cmd_ready = 1 once reset is released.
- Every AXI valid/ready output is driven from a register, with no combinational path from inputs.
- Minimum latency with slaves that are always ready and respond immediately:
  - accept at cycle 0
  - AW/W or AR valid at cycle 1
  - BREADY/RREADY at cycle 2
  - rsp_valid at cycle 3
- Back-to-back: the next command is accepted the cycle after the rsp handshake.
- Reset asserted mid-transaction: all valids drop immediately (asynchronously), the in-flight response is discarded, and the state is IDLE.

## Configuration
- AXI_LITE_CFG_MASTER_TIMEOUT_EN defined:
  - A counter clears on command acceptance and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - When it reaches TIMEOUT_CYCLES-1, the block deasserts all AXI valids/readies on the next edge (a deliberate bus-recovery protocol break) and enters RSP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
- Macro undefined: no counter, rsp_timeout is tied to 0, and the block waits indefinitely.

## Structure
- Package axi_lite_cfg_master_pkg holds:
  - the state enum
  - response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
- The single sub-module is axi_lite_timeout_counter (clear, enable, expired output), instantiated only under the macro.

## Test plan
- Write 0x0000_1000 to 0x4 with wstrb 4'hF, slave always ready, BRESP 0 -> AW/W valid at cycle 1, rsp_valid at cycle 3, rsp_resp 0, rsp_rdata 0.
- AWREADY at cycle 1, WREADY delayed to cycle 4 -> AWVALID drops after cycle 1, WVALID stays high until cycle 4, BREADY rises at cycle 5.
- Read 0x8 where the slave returns RDATA 0xDEADBEEF, RRESP 2'b10 after 3 wait cycles -> rsp_rdata 0xDEADBEEF, rsp_resp 2'b10, held 5 cycles while rsp_ready = 0.
- cmd_valid held high during a busy read -> cmd_ready stays 0, and the second command is accepted the cycle after the rsp handshake.
- Reset pulse while ARVALID = 1 -> ARVALID = 0 immediately, and cmd_ready = 1 the cycle after release.
- With the macro defined and TIMEOUT_CYCLES = 16, the slave never asserts AWREADY -> AWVALID drops, rsp_timeout = 1, rsp_resp 2'b10, 17 cycles after acceptance.
